// File: rtl/ifu_fetch.sv
// ifu_fetch: RV32I instruction fetch unit.
// Owns the fetch PC and issues word fetches to instruction memory. Fetched
// words go to the decoder through a 2-entry buffer with a valid/ready
// handshake. Redirects from jal/jalr/taken branches flush the buffer and
// discard any fetches still in flight.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   imem_req_valid/ready/addr   fetch request channel (word aligned address)
//   imem_rsp_valid/data         fetch response channel (in order, no backpressure)
//   instr_valid/instr/instr_pc  buffer head presented to the decoder
//   instr_ready                 decoder consumes the head this cycle
//   redirect_valid/redirect_pc  control-flow change (one-cycle pulse)
//   fetch_misalign              only with IFU_MISALIGN_TRAP_EN: sticky trap flag
//
// Build option IFU_MISALIGN_TRAP_EN: a redirect to a non word-aligned target
// raises fetch_misalign and parks the unit in HALT until reset. Without it the
// target is aligned down to a word boundary.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef IFU_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misalign
`endif
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned CW   = 2;  // counters hold 0..2

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] data;
  } fetch_ent_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;

  // In-flight PC queue, one slot per possible outstanding request
  logic [XLEN-1:0] ifq_pc [2];
  logic            ifq_wr;
  logic            ifq_rd;

  // Decode buffer: buf0 is the head driven to the decoder
  fetch_ent_t      buf0, buf1;
  logic            buf0_v, buf1_v;
  fetch_ent_t      buf0_n, buf1_n, rsp_ent;
  logic            buf0_v_n, buf1_v_n;

  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic [XLEN-1:0] redirect_tgt;
  logic            redirect_take;
  logic            misalign_hit;
  logic            req_fire;
  logic            rsp_live;
  logic            pop;
  logic [CW-1:0]   outstanding_n;
  logic [CW-1:0]   drop_cnt_n;

  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

`ifdef IFU_MISALIGN_TRAP_EN
  // HALT ignores further redirects; only reset leaves it
  assign redirect_take = redirect_valid && (state != ST_HALT);
  assign misalign_hit  = redirect_take && (redirect_pc[1:0] != 2'b00);
`else
  assign redirect_take = redirect_valid;
  assign misalign_hit  = 1'b0;
`endif

  assign fifo_count  = CW'({1'b0, buf0_v}) + CW'({1'b0, buf1_v});
  // Buffer slots already claimed by entries or by live (non-dropped) fetches
  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(outstanding) - (CW+1)'(drop_cnt);

  assign imem_req_valid = (state == ST_RUN) && !redirect_valid &&
                          (outstanding < CW'(2)) && (credit_used < (CW+1)'(2));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_live = imem_rsp_valid && (drop_cnt == '0) && !redirect_take;
  assign pop      = buf0_v && instr_ready;

  assign instr_valid = buf0_v;
  assign instr       = buf0.data;
  assign instr_pc    = buf0.pc;

  // Outstanding and drop bookkeeping
  always_comb begin
    outstanding_n = CW'(outstanding + CW'(req_fire) - CW'(imem_rsp_valid));
    drop_cnt_n    = drop_cnt;
    if (redirect_take) begin
      // Everything still in flight after this cycle's response becomes stale
      drop_cnt_n = CW'(outstanding - CW'(imem_rsp_valid));
    end else if (imem_rsp_valid && (drop_cnt != '0)) begin
      drop_cnt_n = CW'(drop_cnt - CW'(1));
    end
  end

  // Buffer next state: flush on redirect, else pop then push
  always_comb begin
    buf0_n       = buf0;
    buf1_n       = buf1;
    buf0_v_n     = buf0_v;
    buf1_v_n     = buf1_v;
    rsp_ent.pc   = ifq_pc[ifq_rd];
    rsp_ent.data = imem_rsp_data;
    if (redirect_take) begin
      buf0_v_n = 1'b0;
      buf1_v_n = 1'b0;
    end else begin
      if (pop) begin
        buf0_n   = buf1;
        buf0_v_n = buf1_v;
        buf1_v_n = 1'b0;
      end
      if (rsp_live) begin
        if (!buf0_v_n) begin
          buf0_n   = rsp_ent;
          buf0_v_n = 1'b1;
        end else begin
          buf1_n   = rsp_ent;
          buf1_v_n = 1'b1;
        end
      end
    end
  end

  // State, PC, counters, in-flight queue and buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      ifq_wr      <= 1'b0;
      ifq_rd      <= 1'b0;
      for (int i = 0; i < 2; i++) ifq_pc[i] <= '0;
      buf0        <= '0;
      buf1        <= '0;
      buf0_v      <= 1'b0;
      buf1_v      <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
      fetch_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        ST_BOOT: state <= ST_RUN;
        ST_RUN:  if (misalign_hit) state <= ST_HALT;
        default: state <= state;
      endcase

      if (redirect_take) begin
        fetch_pc <= redirect_tgt;
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(PC_STEP);
      end

      outstanding <= outstanding_n;
      drop_cnt    <= drop_cnt_n;

      if (req_fire) begin
        ifq_pc[ifq_wr] <= fetch_pc;
        ifq_wr         <= ~ifq_wr;
      end
      if (imem_rsp_valid) begin
        ifq_rd <= ~ifq_rd;
      end

      buf0   <= buf0_n;
      buf1   <= buf1_n;
      buf0_v <= buf0_v_n;
      buf1_v <= buf1_v_n;
`ifdef IFU_MISALIGN_TRAP_EN
      if (misalign_hit) fetch_misalign <= 1'b1;
`endif
    end
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit for the RV32I core: owns the PC, issues word fetches to instruction memory, and presents fetched instructions to the decoder (`ctr`) through a 2-entry buffer with a valid/ready handshake.
- Accepts redirects (jal, jalr, taken branch) computed downstream from the decoder's imm, jal, jalr and bxx outputs.
- Discards in-flight fetches made stale by a redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request this cycle.
- imem_req_addr  output  32  word address of fetch (bits [1:0] = 0).
- imem_rsp_valid  input  1  fetch data valid; in order, latency >= 1 cycle, no backpressure.
- imem_rsp_data  input  32  fetched instruction word.
- instr_valid  output  1  buffer head valid.
- instr  output  32  buffer head instruction, to decoder.
- instr_pc  output  32  PC of buffer head.
- instr_ready  input  1  core consumes head this cycle.
- redirect_valid  input  1  control-flow change; one-cycle pulse.
- redirect_pc  input  32  new fetch target.

Behaviour:
- Reset values:
  - fetch_pc = RESET_PC.
  - Buffer empty: instr_valid = 0, instr = 0, instr_pc = 0.
  - outstanding = 0, drop_cnt = 0.
  - State BOOT; imem_req_valid = 0.
- States:
  - BOOT: lasts exactly one cycle, no requests, then RUN.
  - RUN: normal operation.
  - HALT: only with the optional feature enabled.
- Request issue:
  - imem_req_valid = (state == RUN) && !redirect_valid && outstanding < 2 && (fifo_count + outstanding - drop_cnt) < 2.
  - This credit rule guarantees buffer space for every live response.
  - imem_req_addr = fetch_pc.
  - On req_valid && req_ready: fetch_pc += PC_STEP, outstanding++, and the request PC is pushed into a 2-deep in-flight PC queue.
- Response handling:
  - Each imem_rsp_valid: outstanding--, pop in-flight PC queue.
  - If drop_cnt > 0: discard the response, drop_cnt--.
  - Otherwise: push {in-flight PC, imem_rsp_data} into the buffer.
  - A response is visible on instr_valid one cycle after imem_rsp_valid. Minimum fetch-to-decode latency is 2 cycles (req accept -> rsp -> instr_valid).
- Handshake:
  - Head is consumed when instr_valid && instr_ready.
  - instr and instr_pc are held stable while instr_valid && !instr_ready.
  - Push and pop in the same cycle are allowed; fifo_count is unchanged.
- Redirect (redirect_valid = 1):
  - Buffer flushed; pop that cycle is ignored; instr_valid = 0 next cycle.
  - fetch_pc <= redirect_pc.
  - No request is issued in the redirect cycle.
  - Any response arriving in the same cycle is discarded.
  - drop_cnt <= outstanding remaining after that cycle's response accounting.
  - The first request to redirect_pc is issued the cycle after the redirect.
- Back-to-back redirects: the last one wins. drop_cnt accumulates all still-outstanding responses and never exceeds 2.
- Wrap-around: fetch_pc wraps modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- Reset mid-operation: all counters, queues and the buffer clear. imem shares rst, so no responses arrive after reset for pre-reset requests.
- Invariants (asserted in verification): outstanding <= 2, fifo_count <= 2, drop_cnt <= outstanding, no push into a full buffer.

Optional Feature:
- IFU_MISALIGN_TRAP_EN
- Defined:
  - Adds output fetch_misalign (1 bit, reset 0).
  - A redirect with redirect_pc[1:0] != 0 flushes as normal, sets fetch_misalign = 1, and enters HALT.
  - HALT issues no requests and still drains/drops outstanding responses.
  - Only rst leaves HALT. A subsequent redirect is ignored.
- Undefined:
  - No port, no HALT state.
  - redirect_pc[1:0] are forced to 0 (target aligned down).

Test Plan:
- Reset release, memory ready always, latency 1 -> first req addr 0x0 two cycles after rst falls; instr_pc sequence 0x0, 0x4, 0x8 with instr matching the memory image.
- instr_ready held 0 for 10 cycles -> at most 2 requests issued; instr and instr_pc hold 0x0; fetching resumes on release with no lost or duplicated PC.
- Redirect to 0x100 while 2 requests outstanding -> both responses discarded; next instr_pc is 0x100; drop_cnt returns to 0.
- Redirect on the same cycle as imem_rsp_valid and instr_ready -> response dropped, pop ignored, next valid instr_pc = redirect_pc.
- RESET_PC = 32'hFFFF_FFF8 -> fetch addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- With IFU_MISALIGN_TRAP_EN, redirect to 0x102 -> fetch_misalign = 1, imem_req_valid stays 0 until rst; without it, next fetch addr is 0x100.
